fx_mac_lanes: RTL and testbench

- Multi-lane fixed-point multiply-accumulate engine. Successor to the single-lane fixed-K MAC used in the fixed_point datapath.
- LANES parallel MACs share one broadcast activation (din). Each lane has its own weight.
- Accumulation length K is set at run time. Rounding and saturation modes are selectable.
- Input and output use valid/ready handshakes so the block can sit between a line buffer and a downstream requantizer/FIFO.

---
 rtl/fx_mac_lanes_if.sv | 31 +++
 rtl/fx_mac_lanes.sv | 141 ++++++++++++++
 tb/tb_fx_mac_lanes.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fx_mac_lanes_if.sv
// Handshake and data bundle between fx_mac_lanes and its producer/consumer.
// The producer/consumer side uses master; the MAC engine uses slave.
interface fx_mac_lanes_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int KMAX  = 16
);
  localparam int WK = $clog2(KMAX + 1);

  logic [WK-1:0]          cfg_k;
  logic                   rnd_mode;
  logic                   sat_en;
  logic                   in_vld;
  logic                   in_rdy;
  logic [WIDTH-1:0]       din;
  logic [LANES*WIDTH-1:0] win;
  logic                   out_vld;
  logic                   out_rdy;
  logic [LANES*WIDTH-1:0] acc_o;
  logic [LANES-1:0]       ovf;

  modport master (
    output cfg_k, rnd_mode, sat_en, in_vld, din, win, out_rdy,
    input  in_rdy, out_vld, acc_o, ovf
  );

  modport slave (
    input  cfg_k, rnd_mode, sat_en, in_vld, din, win, out_rdy,
    output in_rdy, out_vld, acc_o, ovf
  );
endinterface

// File: rtl/fx_mac_lanes.sv
// Multi-lane fixed-point MAC: one broadcast activation, per-lane weights,
// run-time accumulation length, selectable rounding and saturation.
module fx_mac_lanes #(
  parameter int WIDTH    = 8,
  parameter int FRACTION = 4,
  parameter int LANES    = 4,
  parameter int KMAX     = 16,
  parameter int WK       = $clog2(KMAX + 1),
  parameter int WIDTH_A  = 2*WIDTH + WK + 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            clr,
  fx_mac_lanes_if.slave   bus
);

  typedef enum logic [2:0] {S_IDLE, S_ACC, S_DRAIN, S_RND, S_OUT} state_t;

  localparam logic signed [WIDTH_A-1:0] QMAX = {{(WIDTH_A-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH_A-1:0] QMIN = {{(WIDTH_A-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  state_t                     r_state, w_state_nxt;
  logic                       r_live;
  logic [WK-1:0]              r_k, r_cnt, w_cnt_nxt;
  logic                       r_rnd, r_sat;
  logic                       r_vld_p0;
  logic signed [2*WIDTH-1:0]  r_prod_p0 [LANES];
  logic signed [WIDTH_A-1:0]  r_acc_p1  [LANES];
  logic [LANES*WIDTH-1:0]     r_acc_o;
  logic [LANES-1:0]           r_ovf;
  logic                       w_accept;

  function automatic logic [WK-1:0] eff_k(input logic [WK-1:0] k);
    if (k == '0)             return WK'(1);
    else if (k > WK'(KMAX))  return WK'(KMAX);
    else                     return k;
  endfunction

  function automatic logic signed [WIDTH_A-1:0] round_q(input logic signed [WIDTH_A-1:0] a,
                                                        input logic rnd);
    logic signed [WIDTH_A-1:0] bias;
    bias = '0;
    if (rnd) bias[FRACTION-1] = 1'b1;
    return (a + bias) >>> FRACTION;
  endfunction

  // Returns {overflow flag, lane result}.
  function automatic logic [WIDTH:0] sat_q(input logic signed [WIDTH_A-1:0] r, input logic sat);
    if (r > QMAX)      return {1'b1, sat ? {1'b0, {(WIDTH-1){1'b1}}} : r[WIDTH-1:0]};
    else if (r < QMIN) return {1'b1, sat ? {1'b1, {(WIDTH-1){1'b0}}} : r[WIDTH-1:0]};
    else               return {1'b0, r[WIDTH-1:0]};
  endfunction

  assign w_accept    = bus.in_vld & bus.in_rdy;
  assign bus.in_rdy  = r_live & ((r_state == S_IDLE) | (r_state == S_ACC));
  assign bus.out_vld = (r_state == S_OUT);
  assign bus.acc_o   = r_acc_o;
  assign bus.ovf     = r_ovf;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (clr) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          w_cnt_nxt   = WK'(1);
          w_state_nxt = (eff_k(bus.cfg_k) == WK'(1)) ? S_DRAIN : S_ACC;
        end
        S_ACC: if (w_accept) begin
          w_cnt_nxt = r_cnt + WK'(1);
          if (r_cnt + WK'(1) == r_k) w_state_nxt = S_DRAIN;
        end
        // Leave DRAIN only once the final product has landed in the accumulator.
        S_DRAIN: if (!r_vld_p0) w_state_nxt = S_RND;
        S_RND:   w_state_nxt = S_OUT;
        S_OUT: if (bus.out_rdy) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_live   <= 1'b0;
      r_k      <= '0;
      r_cnt    <= '0;
      r_rnd    <= 1'b0;
      r_sat    <= 1'b0;
      r_vld_p0 <= 1'b0;
      r_acc_o  <= '0;
      r_ovf    <= '0;
      for (int i = 0; i < LANES; i++) begin
        r_prod_p0[i] <= '0;
        r_acc_p1[i]  <= '0;
      end
    end else begin
      r_live  <= 1'b1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (clr) begin
        r_vld_p0 <= 1'b0;
        for (int i = 0; i < LANES; i++) begin
          r_prod_p0[i] <= '0;
          r_acc_p1[i]  <= '0;
        end
      end else begin
        if (r_state == S_IDLE && w_accept) begin
          r_k   <= eff_k(bus.cfg_k);
          r_rnd <= bus.rnd_mode;
          r_sat <= bus.sat_en;
        end
        // p0: full-precision product on the accept edge
        r_vld_p0 <= w_accept;
        for (int i = 0; i < LANES; i++) begin
          if (w_accept)
            r_prod_p0[i] <= $signed(bus.din) * $signed(bus.win[i*WIDTH +: WIDTH]);
        end
        // p1: accumulate; cleared when the result is handed off
        for (int i = 0; i < LANES; i++) begin
          if (r_vld_p0)
            r_acc_p1[i] <= r_acc_p1[i] + WIDTH_A'(r_prod_p0[i]);
          else if (r_state == S_OUT && bus.out_rdy)
            r_acc_p1[i] <= '0;
        end
        // p2: round and clamp into the output registers
        if (r_state == S_RND) begin
          for (int i = 0; i < LANES; i++)
            {r_ovf[i], r_acc_o[i*WIDTH +: WIDTH]} <= sat_q(round_q(r_acc_p1[i], r_rnd), r_sat);
        end
      end
    end
  end

endmodule

// File: tb/tb_fx_mac_lanes.sv
// Bench for fx_mac_lanes: directed windows plus randomized windows checked
// against an arithmetic model of the MAC, rounding and saturation rules.
module tb_fx_mac_lanes;
  localparam int WIDTH    = 8;
  localparam int FRACTION = 4;
  localparam int LANES    = 4;
  localparam int KMAX     = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic clr  = 1'b0;
  always #5 clk = ~clk;

  fx_mac_lanes_if #(.WIDTH(WIDTH), .LANES(LANES), .KMAX(KMAX)) bus ();

  fx_mac_lanes #(.WIDTH(WIDTH), .FRACTION(FRACTION), .LANES(LANES), .KMAX(KMAX)) dut (
    .clk  (clk),
    .rstn (rstn),
    .clr  (clr),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [WIDTH-1:0]       b_din [KMAX];
  logic [LANES*WIDTH-1:0] b_win [KMAX];
  logic [LANES*WIDTH-1:0] exp_acc;
  logic [LANES-1:0]       exp_ovf;

  function automatic int eff(input int k);
    if (k == 0) return 1;
    if (k > KMAX) return KMAX;
    return k;
  endfunction

  function automatic longint floor_div(input longint num, input longint den);
    if (num >= 0) return num / den;
    return -((-num + den - 1) / den);
  endfunction

  // Dot product per lane, then round/clamp from the plain arithmetic rules.
  function automatic void model(input int k, input bit rnd, input bit sat);
    longint s, r, v;
    logic signed [WIDTH-1:0] a8, w8;
    int vi;
    for (int l = 0; l < LANES; l++) begin
      s = 0;
      for (int b = 0; b < eff(k); b++) begin
        a8 = b_din[b];
        w8 = b_win[b][l*WIDTH +: WIDTH];
        s += longint'(a8) * longint'(w8);
      end
      r = floor_div(s + (rnd ? longint'(1 << (FRACTION-1)) : 0), longint'(1 << FRACTION));
      exp_ovf[l] = (r > 127) || (r < -128);
      if (sat && r > 127)       v = 127;
      else if (sat && r < -128) v = -128;
      else                      v = r;
      vi = int'(v);
      exp_acc[l*WIDTH +: WIDTH] = vi[WIDTH-1:0];
    end
  endfunction

  task automatic feed(input int n, input bit gaps, input int chg_at);
    int idx = 0;
    int guard = 0;
    bit phase = 1'b0;
    logic acc;
    while (idx < n && guard < 400) begin
      @(negedge clk);
      phase = ~phase;
      bus.in_vld = gaps ? phase : 1'b1;
      bus.din    = b_din[idx];
      bus.win    = b_win[idx];
      if (chg_at > 0 && idx == chg_at) begin
        bus.cfg_k    = 5'd3;
        bus.rnd_mode = 1'b1;
        bus.sat_en   = 1'b0;
      end
      acc = bus.in_vld & bus.in_rdy;
      @(posedge clk);
      if (acc) idx++;
      guard++;
    end
    #1 bus.in_vld = 1'b0;
    if (idx < n) begin
      n_vec++; n_err++;
      $display("FAIL feed_timeout: accepted %0d beats, required %0d", idx, n);
    end
  endtask

  task automatic run_window(input int k, input bit rnd, input bit sat, input bit gaps,
                            input int hold, input int chg_at, input string tag);
    int lat = 0;
    bit seen = 1'b0;
    logic [4:0] kb;
    model(k, rnd, sat);
    kb = k[4:0];
    bus.cfg_k    = kb;
    bus.rnd_mode = rnd;
    bus.sat_en   = sat;
    bus.out_rdy  = (hold == 0);
    feed(eff(k), gaps, chg_at);
    while (!seen && lat < 12) begin
      @(posedge clk); lat++; #1;
      if (bus.out_vld === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (lat != 3) begin n_err++; $display("FAIL %s latency: got %0d edges, want 3", tag, lat); end
    n_vec++;
    if (bus.acc_o !== exp_acc) begin n_err++; $display("FAIL %s acc_o: got %h, want %h", tag, bus.acc_o, exp_acc); end
    n_vec++;
    if (bus.ovf !== exp_ovf) begin n_err++; $display("FAIL %s ovf: got %b, want %b", tag, bus.ovf, exp_ovf); end
    n_vec++;
    if (bus.in_rdy !== 1'b0) begin n_err++; $display("FAIL %s in_rdy_out: got %b, want 0", tag, bus.in_rdy); end
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        n_vec++;
        if (bus.out_vld !== 1'b1 || bus.acc_o !== exp_acc || bus.in_rdy !== 1'b0) begin
          n_err++;
          $display("FAIL %s hold[%0d]: got vld=%b acc=%h rdy=%b, want vld=1 acc=%h rdy=0",
                   tag, h, bus.out_vld, bus.acc_o, bus.in_rdy, exp_acc);
        end
      end
      @(negedge clk); bus.out_rdy = 1'b1;
    end
    @(posedge clk); #1;
    n_vec++;
    if (bus.out_vld !== 1'b0) begin n_err++; $display("FAIL %s out_vld_drop: got %b, want 0", tag, bus.out_vld); end
    n_vec++;
    if (bus.in_rdy !== 1'b1) begin n_err++; $display("FAIL %s in_rdy_back: got %b, want 1", tag, bus.in_rdy); end
  endtask

  task automatic load_case1();
    for (int b = 0; b < KMAX; b++) begin
      b_din[b] = 8'h04;
      b_win[b] = {8'h00, 8'hF8, 8'h10, 8'h08};
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_vec++;
    if (bus.in_rdy !== 1'b0) begin n_err++; $display("FAIL reset_in_rdy: got %b, want 0", bus.in_rdy); end
    n_vec++;
    if (bus.out_vld !== 1'b0) begin n_err++; $display("FAIL reset_out_vld: got %b, want 0", bus.out_vld); end
    n_vec++;
    if (bus.acc_o !== '0 || bus.ovf !== '0) begin
      n_err++; $display("FAIL reset_outputs: got acc=%h ovf=%b, want 0/0", bus.acc_o, bus.ovf);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (bus.in_rdy !== 1'b1) begin n_err++; $display("FAIL reset_release_rdy: got %b, want 1", bus.in_rdy); end
  endtask

  task automatic test_basic();
    load_case1();
    run_window(9, 1'b0, 1'b1, 1'b0, 0, 0, "basic_k9");
  endtask

  task automatic test_rounding();
    b_din[0] = 8'h08;
    b_win[0] = {8'h00, 8'h03, 8'hFF, 8'h01};
    run_window(1, 1'b1, 1'b1, 1'b0, 0, 0, "round_half_up");
    run_window(1, 1'b0, 1'b1, 1'b0, 0, 0, "round_floor");
    run_window(0, 1'b1, 1'b0, 1'b0, 0, 0, "k0_as_1");
  endtask

  task automatic test_saturation();
    for (int b = 0; b < KMAX; b++) begin
      b_din[b] = 8'h7F;
      b_win[b] = {8'h00, 8'h01, 8'h80, 8'h7F};
    end
    run_window(16, 1'b0, 1'b1, 1'b0, 0, 0, "sat_on");
    run_window(16, 1'b0, 1'b0, 1'b0, 0, 0, "sat_off");
    run_window(20, 1'b1, 1'b1, 1'b0, 0, 0, "k_clamp_kmax");
  endtask

  task automatic test_back_pressure();
    load_case1();
    run_window(9, 1'b0, 1'b1, 1'b0, 10, 0, "back_pressure");
  endtask

  task automatic test_gaps_cfg_change();
    load_case1();
    run_window(9, 1'b0, 1'b1, 1'b1, 0, 2, "gaps_cfg_change");
  endtask

  task automatic test_clr();
    load_case1();
    bus.cfg_k = 5'd9; bus.rnd_mode = 1'b0; bus.sat_en = 1'b1; bus.out_rdy = 1'b1;
    feed(4, 1'b0, 0);
    @(negedge clk);
    bus.in_vld = 1'b1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    bus.in_vld = 1'b0;
    n_vec++;
    if (bus.out_vld !== 1'b0 || bus.in_rdy !== 1'b1) begin
      n_err++; $display("FAIL clr_idle: got vld=%b rdy=%b, want 0/1", bus.out_vld, bus.in_rdy);
    end
    run_window(9, 1'b0, 1'b1, 1'b0, 0, 0, "after_clr");
  endtask

  task automatic test_async_reset();
    load_case1();
    bus.cfg_k = 5'd9; bus.rnd_mode = 1'b0; bus.sat_en = 1'b1; bus.out_rdy = 1'b1;
    feed(4, 1'b0, 0);
    #2 rstn = 1'b0;
    #1;
    n_vec++;
    if (bus.out_vld !== 1'b0 || bus.acc_o !== '0 || bus.ovf !== '0 || bus.in_rdy !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got vld=%b acc=%h ovf=%b rdy=%b, want all 0",
               bus.out_vld, bus.acc_o, bus.ovf, bus.in_rdy);
    end
    @(negedge clk); rstn = 1'b1;
    run_window(9, 1'b0, 1'b1, 1'b0, 0, 0, "after_async_reset");
  endtask

  task automatic test_random();
    int k, hold;
    bit rnd, sat, gaps;
    for (int it = 0; it < 16; it++) begin
      k    = int'($urandom_range(0, 20));
      rnd  = 1'($urandom_range(0, 1));
      sat  = 1'($urandom_range(0, 1));
      gaps = 1'($urandom_range(0, 1));
      hold = int'($urandom_range(0, 3));
      for (int b = 0; b < KMAX; b++) begin
        b_din[b] = 8'($urandom);
        b_win[b] = $urandom;
      end
      run_window(k, rnd, sat, gaps, hold, 0, $sformatf("random%0d", it));
    end
  endtask

  initial begin
    bus.cfg_k = '0; bus.rnd_mode = 1'b0; bus.sat_en = 1'b0;
    bus.in_vld = 1'b0; bus.din = '0; bus.win = '0; bus.out_rdy = 1'b0;
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_back_pressure();
    test_gaps_cfg_change();
    test_clr();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
    $fatal(1);
  end

endmodule
